// File: rtl/axi_burst_sched_if.sv
// AXI4 master-side bus bundle used by axi_burst_sched (master modport) and by the
// memory-controller slave (slave modport).
interface axi_burst_sched_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 6
);
  logic [ID_W-1:0]     awid;
  logic [ADDR_W-1:0]   awaddr;
  logic [7:0]          awlen;
  logic [2:0]          awsize;
  logic [1:0]          awburst;
  logic                awlock;
  logic [3:0]          awcache;
  logic [2:0]          awprot;
  logic [3:0]          awqos;
  logic                awvalid;
  logic                awready;

  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;
  logic                wvalid;
  logic                wready;

  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  logic [ID_W-1:0]     arid;
  logic [ADDR_W-1:0]   araddr;
  logic [7:0]          arlen;
  logic [2:0]          arsize;
  logic [1:0]          arburst;
  logic                arlock;
  logic [3:0]          arcache;
  logic [2:0]          arprot;
  logic [3:0]          arqos;
  logic                arvalid;
  logic                arready;

  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    input  awready,
    output wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
    output awready,
    input  wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_burst_sched.sv
// Two-requester round-robin scheduler driving one AXI4 master port, one burst at a time.
// Define AXI_SCHED_ERR_CNT_EN to build the saturating error-event counter on err_cnt.
module axi_burst_sched #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 6
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_write,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [15:0]         req_len,
  output logic                gnt_id,
  output logic                busy,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                rd_last,
  input  logic                rd_ready,
  output logic                txn_done,
  axi_burst_sched_if.master   m_axi,
  output logic [15:0]         err_cnt
);

  localparam logic [2:0] AXSIZE = 3'($clog2(DATA_W/8));

  typedef enum logic [2:0] {
    S_IDLE, S_AR, S_RDATA, S_AW, S_WDATA, S_BRESP
  } state_e;

  state_e            state_q, state_d;
  logic              arm_q, arm_d;
  logic              last_q, last_d;
  logic              gnt_q, gnt_d;
  logic              txn_done_q, txn_done_d;
  logic              arvalid_q, arvalid_d;
  logic              awvalid_q, awvalid_d;
  logic              bready_q, bready_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        len_q, len_d;

  logic grant;
  logic accept;
  logic r_hs;
  logic w_hs;
  logic w_last_beat;

  // arm_q keeps req_ready low while reset is asserted even though state reads IDLE
  always_comb begin
    grant       = (&req_valid) ? ~last_q : req_valid[1];
    req_ready   = (arm_q && state_q == S_IDLE && req_valid[grant]) ? (2'b01 << grant) : 2'b00;
    accept      = |req_ready;
    r_hs        = (state_q == S_RDATA) && m_axi.rvalid && rd_ready;
    w_last_beat = (cnt_q == len_q);
    w_hs        = (state_q == S_WDATA) && wr_valid && m_axi.wready;
  end

  always_comb begin
    state_d    = state_q;
    arm_d      = 1'b1;
    last_d     = last_q;
    gnt_d      = gnt_q;
    txn_done_d = 1'b0;
    arvalid_d  = arvalid_q;
    awvalid_d  = awvalid_q;
    bready_d   = bready_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    len_d      = len_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          addr_d = grant ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          len_d  = grant ? req_len[15:8] : req_len[7:0];
          gnt_d  = grant;
          last_d = grant;
          cnt_d  = 8'd0;
          if (req_write[grant]) begin
            state_d   = S_AW;
            awvalid_d = 1'b1;
          end else begin
            state_d   = S_AR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_AR: begin
        if (m_axi.arready) begin
          arvalid_d = 1'b0;
          state_d   = S_RDATA;
        end
      end
      S_RDATA: begin
        if (r_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (m_axi.rlast) begin
            state_d    = S_IDLE;
            txn_done_d = 1'b1;
          end
        end
      end
      S_AW: begin
        if (m_axi.awready) begin
          awvalid_d = 1'b0;
          state_d   = S_WDATA;
        end
      end
      S_WDATA: begin
        if (w_hs) begin
          cnt_d = cnt_q + 8'd1;
          if (w_last_beat) begin
            state_d  = S_BRESP;
            bready_d = 1'b1;
          end
        end
      end
      S_BRESP: begin
        if (m_axi.bvalid) begin
          bready_d   = 1'b0;
          state_d    = S_IDLE;
          txn_done_d = 1'b1;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
        awvalid_d = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= S_IDLE;
      arm_q      <= 1'b0;
      last_q     <= 1'b1;
      gnt_q      <= 1'b0;
      txn_done_q <= 1'b0;
      arvalid_q  <= 1'b0;
      awvalid_q  <= 1'b0;
      bready_q   <= 1'b0;
      cnt_q      <= 8'd0;
    end else begin
      state_q    <= state_d;
      arm_q      <= arm_d;
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      txn_done_q <= txn_done_d;
      arvalid_q  <= arvalid_d;
      awvalid_q  <= awvalid_d;
      bready_q   <= bready_d;
      cnt_q      <= cnt_d;
    end
  end

  // Command payload only matters once a handshake has loaded it
  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    len_q  <= len_d;
  end

  assign gnt_id   = gnt_q;
  assign busy     = (state_q != S_IDLE);
  assign txn_done = txn_done_q;

  assign m_axi.awid    = '0;
  assign m_axi.awaddr  = addr_q;
  assign m_axi.awlen   = len_q;
  assign m_axi.awsize  = AXSIZE;
  assign m_axi.awburst = 2'b01;
  assign m_axi.awlock  = 1'b0;
  assign m_axi.awcache = 4'd0;
  assign m_axi.awprot  = 3'd0;
  assign m_axi.awqos   = 4'd0;
  assign m_axi.awvalid = awvalid_q;

  assign m_axi.arid    = '0;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arlen   = len_q;
  assign m_axi.arsize  = AXSIZE;
  assign m_axi.arburst = 2'b01;
  assign m_axi.arlock  = 1'b0;
  assign m_axi.arcache = 4'd0;
  assign m_axi.arprot  = 3'd0;
  assign m_axi.arqos   = 4'd0;
  assign m_axi.arvalid = arvalid_q;

  // W and R beats are straight pass-throughs, gated so nothing leaks outside their phase
  assign m_axi.wdata  = wr_data;
  assign m_axi.wstrb  = '1;
  assign m_axi.wlast  = (state_q == S_WDATA) && w_last_beat;
  assign m_axi.wvalid = (state_q == S_WDATA) && wr_valid;
  assign wr_ready     = (state_q == S_WDATA) && m_axi.wready;

  assign m_axi.bready = bready_q;

  assign rd_data      = m_axi.rdata;
  assign rd_valid     = (state_q == S_RDATA) && m_axi.rvalid;
  assign rd_last      = (state_q == S_RDATA) && m_axi.rlast;
  assign m_axi.rready = (state_q == S_RDATA) && rd_ready;

`ifdef AXI_SCHED_ERR_CNT_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic        err_evt;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Only one channel is live per state, so at most one event can fire per cycle
  always_comb begin
    err_evt   = (r_hs && ((m_axi.rresp != 2'b00) || (m_axi.rlast && (cnt_q != len_q)))) ||
                ((state_q == S_BRESP) && m_axi.bvalid && (m_axi.bresp != 2'b00));
    err_cnt_d = err_evt ? sat_inc(err_cnt_q) : err_cnt_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) err_cnt_q <= 16'd0;
    else       err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_axi_burst_sched.sv
// Scoreboard bench for axi_burst_sched: directed requests push expected AR/AW, beats and
// completions into queues; a negedge monitor pops and compares as the DUT presents them.
module tb_axi_burst_sched;

`ifdef AXI_SCHED_ERR_CNT_EN
  localparam int EXP_ERR = 2;
`else
  localparam int EXP_ERR = 0;
`endif

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [7:0]  hold;
  } cmd_t;

  typedef struct packed {
    logic [63:0] data;
    logic        last;
  } beat_t;

  logic        clk = 1'b0;
  logic        rstn;
  logic [1:0]  req_valid, req_write, req_ready;
  logic [63:0] req_addr;
  logic [15:0] req_len;
  logic        gnt_id, busy;
  logic [63:0] wr_data, rd_data;
  logic        wr_valid, wr_ready;
  logic        rd_valid, rd_last, rd_ready;
  logic        txn_done;
  logic [15:0] err_cnt;

  axi_burst_sched_if #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) bus ();

  axi_burst_sched #(.ADDR_W(32), .DATA_W(64), .ID_W(6)) dut (
    .clk(clk), .rstn(rstn),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .gnt_id(gnt_id), .busy(busy),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
    .txn_done(txn_done), .m_axi(bus), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  cmd_t  exp_ar[$], exp_aw[$];
  beat_t exp_rd[$], exp_w[$];
  logic  exp_done[$];

  // slave knobs
  int         ar_hold = 1, aw_hold = 1, b_delay = 0, r_beats_cfg = 0;
  logic       w_toggle = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;

  // write-data source state
  logic [63:0] wbase = 64'd0;
  int          wcnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] rdat(input logic [31:0] a, input int i);
    return {a, 32'(i)};
  endfunction

  // ---------------- slave model ----------------
  initial begin
    logic [31:0] la;
    logic [7:0]  ll;
    int          nb;
    logic        phase, hs, lst, wdone;
    bus.awready = 0; bus.arready = 0; bus.wready = 0;
    bus.bvalid = 0; bus.bresp = 0; bus.bid = 0;
    bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0; bus.rid = 0;
    forever begin
      @(posedge clk); #1;
      if (rstn && bus.arvalid) begin
        la = bus.araddr; ll = bus.arlen;
        repeat (ar_hold - 1) begin @(posedge clk); #1; end
        bus.arready = 1; @(posedge clk); #1; bus.arready = 0;
        nb = (r_beats_cfg != 0) ? r_beats_cfg : int'(ll) + 1;
        for (int i = 0; i < nb && rstn; i++) begin
          bus.rvalid = 1; bus.rdata = rdat(la, i); bus.rlast = (i == nb - 1);
          @(negedge clk);
          while (rstn && !bus.rready) @(negedge clk);
          @(posedge clk); #1;
        end
        bus.rvalid = 0; bus.rlast = 0;
      end else if (rstn && bus.awvalid) begin
        repeat (aw_hold - 1) begin @(posedge clk); #1; end
        bus.awready = 1; @(posedge clk); #1; bus.awready = 0;
        phase = 1; wdone = 0;
        while (rstn && !wdone) begin
          bus.wready = w_toggle ? phase : 1'b1;
          phase = !phase;
          @(negedge clk);
          hs = bus.wvalid && bus.wready; lst = bus.wlast;
          @(posedge clk); #1;
          if (hs && lst) wdone = 1;
        end
        bus.wready = 0;
        if (wdone) begin
          repeat (b_delay) begin @(posedge clk); #1; end
          bus.bvalid = 1; bus.bresp = bresp_cfg;
          @(negedge clk);
          while (rstn && !bus.bready) @(negedge clk);
          @(posedge clk); #1;
          bus.bvalid = 0; bus.bresp = 0;
        end
      end
    end
  end

  // ---------------- requester write-data source ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!rstn || txn_done) begin
        wcnt = 0;
        wr_data = wbase;
      end else if (wr_valid && wr_ready) begin
        @(posedge clk); #1;
        wcnt++;
        wr_data = wbase + 64'(wcnt);
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic aw_open = 0, in_b = 0;
    int   arv_cnt = 0, awv_cnt = 0;
    cmd_t  c;
    beat_t b;
    logic  g;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        aw_open = 0; in_b = 0; arv_cnt = 0; awv_cnt = 0;
      end else begin
        if (in_b) chk("bready_held", 64'(bus.bready), 64'd1);
        if (bus.arvalid) arv_cnt++;
        if (bus.awvalid) awv_cnt++;
        if (bus.arvalid && bus.arready) begin
          chk("ar_expected", 64'(exp_ar.size() != 0), 64'd1);
          if (exp_ar.size() != 0) begin
            c = exp_ar.pop_front();
            chk("araddr", 64'(bus.araddr), 64'(c.addr));
            chk("arlen", 64'(bus.arlen), 64'(c.len));
            chk("arvalid_cycles", 64'(arv_cnt), 64'(c.hold));
            chk("arsize_burst", 64'({bus.arsize, bus.arburst, bus.arid}), 64'({3'd3, 2'b01, 6'd0}));
          end
          arv_cnt = 0;
        end
        if (bus.awvalid && bus.awready) begin
          chk("aw_expected", 64'(exp_aw.size() != 0), 64'd1);
          if (exp_aw.size() != 0) begin
            c = exp_aw.pop_front();
            chk("awaddr", 64'(bus.awaddr), 64'(c.addr));
            chk("awlen", 64'(bus.awlen), 64'(c.len));
            chk("awvalid_cycles", 64'(awv_cnt), 64'(c.hold));
            chk("awsize_burst", 64'({bus.awsize, bus.awburst, bus.awid}), 64'({3'd3, 2'b01, 6'd0}));
          end
          awv_cnt = 0;
        end
        if (bus.wvalid) chk("wvalid_after_aw", 64'(aw_open), 64'd1);
        if (bus.awvalid && bus.awready) aw_open = 1;
        if (bus.wvalid && bus.wready) begin
          chk("w_expected", 64'(exp_w.size() != 0), 64'd1);
          if (exp_w.size() != 0) begin
            b = exp_w.pop_front();
            chk("wdata", bus.wdata, b.data);
            chk("wlast", 64'(bus.wlast), 64'(b.last));
            chk("wstrb", 64'(bus.wstrb), 64'hFF);
          end
          if (bus.wlast) in_b = 1;
        end
        if (bus.bvalid && bus.bready) begin
          in_b = 0; aw_open = 0;
        end
        if (rd_valid && rd_ready) begin
          chk("rd_expected", 64'(exp_rd.size() != 0), 64'd1);
          if (exp_rd.size() != 0) begin
            b = exp_rd.pop_front();
            chk("rd_data", rd_data, b.data);
            chk("rd_last", 64'(rd_last), 64'(b.last));
          end
        end
        if (txn_done) begin
          chk("done_expected", 64'(exp_done.size() != 0), 64'd1);
          if (exp_done.size() != 0) begin
            g = exp_done.pop_front();
            chk("gnt_id", 64'(gnt_id), 64'(g));
          end
          chk("idle_at_done", 64'(busy), 64'd0);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_read(input logic r, input logic [31:0] a, input logic [7:0] l,
                           input int nb, input int hold);
    exp_ar.push_back('{addr: a, len: l, hold: 8'(hold)});
    for (int i = 0; i < nb; i++) exp_rd.push_back('{data: rdat(a, i), last: (i == nb - 1)});
    exp_done.push_back(r);
  endtask

  task automatic push_write(input logic r, input logic [31:0] a, input logic [7:0] l,
                            input logic [63:0] base, input int hold);
    exp_aw.push_back('{addr: a, len: l, hold: 8'(hold)});
    for (int i = 0; i <= int'(l); i++) exp_w.push_back('{data: base + 64'(i), last: (i == int'(l))});
    exp_done.push_back(r);
  endtask

  task automatic issue(input int r, input logic w, input logic [31:0] a, input logic [7:0] l);
    int cyc = 0;
    @(posedge clk); #1;
    req_addr[r*32 +: 32] = a;
    req_len[r*8 +: 8]    = l;
    req_write[r]         = w;
    req_valid[r]         = 1'b1;
    @(negedge clk);
    while (!req_ready[r] && cyc < 100) begin @(negedge clk); cyc++; end
    chk("req_accept", 64'(req_ready[r]), 64'd1);
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
    @(negedge clk);
    if (w) chk("awvalid_latency", 64'(bus.awvalid), 64'd1);
    else   chk("arvalid_latency", 64'(bus.arvalid), 64'd1);
  endtask

  task automatic wait_done(input int n);
    int seen = 0, cyc = 0;
    while (seen < n && cyc < 300) begin
      @(negedge clk);
      if (txn_done) seen++;
      cyc++;
    end
    chk("done_count", 64'(seen), 64'(n));
  endtask

  initial begin
    #400000;
    fails++; tests++;
    $display("FAIL watchdog: got no completion, expected end of stimulus");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // ---------------- directed tests ----------------
  initial begin
    int n, cyc;
    rstn = 0; req_valid = 2'b11; req_write = 0; req_addr = 0; req_len = 0;
    wr_valid = 1; wr_data = 0; rd_ready = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valids", 64'({bus.arvalid, bus.awvalid, bus.wvalid, bus.bready, bus.rready}), 64'd0);
    chk("rst_wr_ready_txn_done", 64'({wr_ready, txn_done, rd_valid}), 64'd0);
    chk("rst_gnt_id", 64'(gnt_id), 64'd0);
    chk("rst_err_cnt", 64'(err_cnt), 64'd0);
    req_valid = 2'b00;
    @(posedge clk); #1; rstn = 1;

    // read, requester 0, 8 beats
    push_read(1'b0, 32'h1000, 8'd7, 8, 1);
    issue(0, 1'b0, 32'h1000, 8'd7);
    wait_done(1);

    // write, requester 1, wready toggling, delayed B
    w_toggle = 1; b_delay = 2;
    wbase = 64'hA0; wr_data = wbase;
    push_write(1'b1, 32'h2000, 8'd3, 64'hA0, 1);
    issue(1, 1'b1, 32'h2000, 8'd3);
    wait_done(1);
    w_toggle = 0; b_delay = 0;

    // both requesters continuously valid: grants alternate
    for (int k = 0; k < 4; k++) push_read(k[0], (k[0] ? 32'h4000 : 32'h3000), 8'd1, 2, 1);
    @(posedge clk); #1;
    req_addr = {32'h4000, 32'h3000}; req_len = {8'd1, 8'd1}; req_write = 2'b00;
    req_valid = 2'b11;
    n = 0; cyc = 0;
    while (n < 4 && cyc < 300) begin
      @(negedge clk);
      if (txn_done) n++;
      cyc++;
    end
    req_valid = 2'b00;
    chk("alt_done_count", 64'(n), 64'd4);

    // error events: bad bresp, short read burst
    bresp_cfg = 2'b10;
    wbase = 64'hB0; wr_data = wbase;
    push_write(1'b0, 32'h5000, 8'd0, 64'hB0, 1);
    issue(0, 1'b1, 32'h5000, 8'd0);
    wait_done(1);
    bresp_cfg = 2'b00;
    r_beats_cfg = 3;
    push_read(1'b1, 32'h6000, 8'd7, 3, 1);
    issue(1, 1'b0, 32'h6000, 8'd7);
    wait_done(1);
    r_beats_cfg = 0;
    @(negedge clk);
    chk("err_cnt", 64'(err_cnt), 64'(EXP_ERR));

    // reset in the middle of a write burst
    wbase = 64'hC0; wr_data = wbase;
    push_write(1'b0, 32'h7000, 8'd3, 64'hC0, 1);
    issue(0, 1'b1, 32'h7000, 8'd3);
    cyc = 0;
    while (!(wcnt == 1 && bus.wvalid) && cyc < 50) begin @(negedge clk); cyc++; end
    chk("reached_beat2", 64'(wcnt), 64'd1);
    #2 rstn = 0;
    #1;
    chk("async_wvalid", 64'(bus.wvalid), 64'd0);
    chk("async_wr_ready", 64'(wr_ready), 64'd0);
    chk("async_busy", 64'(busy), 64'd0);
    exp_aw.delete(); exp_w.delete(); exp_done.delete();
    req_addr = {32'h8800, 32'h8000}; req_len = 16'd0; req_write = 2'b00;
    req_valid = 2'b11;
    #1;
    chk("rst_hold_req_ready", 64'(req_ready), 64'd0);
    chk("rst_err_clear", 64'(err_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1 rstn = 1;
    @(posedge clk);
    @(negedge clk);
    chk("post_rst_tie", 64'(req_ready), 64'b01);
    chk("post_rst_busy", 64'(busy), 64'd0);
    req_valid = 2'b00;

    // len-0 write and len-0 read with slow address ready
    aw_hold = 5; ar_hold = 5;
    wbase = 64'hD0; wr_data = wbase;
    push_write(1'b1, 32'h8000, 8'd0, 64'hD0, 5);
    issue(1, 1'b1, 32'h8000, 8'd0);
    wait_done(1);
    push_read(1'b0, 32'h9000, 8'd0, 1, 5);
    issue(0, 1'b0, 32'h9000, 8'd0);
    wait_done(1);
    aw_hold = 1; ar_hold = 1;

    repeat (3) @(negedge clk);
    chk("leftover_expectations",
        64'(exp_ar.size() + exp_aw.size() + exp_rd.size() + exp_w.size() + exp_done.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/axi_burst_sched.md
Name: axi_burst_sched

Overview:
- Synthesizable scheduler that shares one AXI4 master port between two requesters (e.g. CPU-side command path and a DMA/test-traffic engine).
- Takes single-burst read/write commands, arbitrates round-robin, and sequences the full AR/R or AW/W/B exchange.
- Exactly one transaction is outstanding at a time.
- Sits between the requesters and the memory controller AXI slave.

Parameters:
- ADDR_W, 32, AXI address width.
- DATA_W, 64, AXI data width; beat size = DATA_W/8 bytes.
- ID_W, 6, AXI ID width. All IDs are driven 0.

Ports:
- clk  in  1  system clock.
- rstn  in  1  asynchronous active-low reset.
- req_valid  in  2  per-requester command valid.
- req_ready  out  2  per-requester command accept.
- req_write  in  2  1 = write burst, 0 = read burst.
- req_addr  in  2*ADDR_W  start address; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_len  in  16  AXI len (beats-1); requester i uses bits [i*8 +: 8].
- gnt_id  out  1  requester that owns the current transaction.
- busy  out  1  high whenever state != IDLE.
- wr_data  in  DATA_W  write beat from the owner.
- wr_valid  in  1  write beat valid.
- wr_ready  out  1  write beat accepted.
- rd_data  out  DATA_W  read beat to the owner.
- rd_valid  out  1  read beat valid.
- rd_last  out  1  final read beat.
- rd_ready  in  1  owner accepts the read beat.
- txn_done  out  1  one-cycle pulse at transaction end.
- m_axi_aw*  out  AW channel: id, addr, len, size, burst, lock, cache, prot, qos, valid; m_axi_awready in.
- m_axi_w*  out  W channel: data, strb, last, valid; m_axi_wready in.
- m_axi_b*  B channel: bid, bresp, bvalid in; m_axi_bready out.
- m_axi_ar*  out  AR channel, same fields as AW; m_axi_arready in.
- m_axi_r*  R channel: rid, rdata, rresp, rlast, rvalid in; m_axi_rready out.
- err_cnt  out  16  error count (see Optional Feature).

Behaviour:
- Constant outputs: size = log2(DATA_W/8) (3 at default); burst = INCR (2'b01); wstrb all ones; lock, cache, prot, qos, ids = 0.
- States: IDLE, AR, RDATA, AW, WDATA, BRESP.
- Reset: asynchronous and immediate, including mid-burst. In reset:
  - state = IDLE; all AXI valids, bready, rready, req_ready, wr_ready, rd_valid and txn_done = 0.
  - gnt_id = 0; round-robin pointer last = 1, so requester 0 wins the first tie.
  - A burst interrupted by reset is abandoned; nothing is replayed.
- IDLE, arbitration:
  - Combinational grant: the sole valid requester, or the requester != last when both are valid.
  - req_ready[g] = 1 only in IDLE for the granted requester. The other requester's req_ready = 0.
  - On handshake: latch addr, len, write and g into gnt_id; update last = g.
  - Next cycle: AW if write, AR if read.
- AR: arvalid = 1 with the latched addr/len, held until the arready cycle, then go to RDATA. arvalid must not wait on arready.
- RDATA:
  - Combinational pass-through: rd_data = rdata, rd_valid = rvalid, rd_last = rlast, rready = rd_ready.
  - An 8-bit beat counter increments on each rvalid && rready.
  - On the handshake with rlast = 1: txn_done pulses next cycle, then IDLE.
  - Counter mismatch at rlast (count != len) is an error event.
- AW: awvalid = 1 until the awready cycle, then go to WDATA. W beats are not sent before the AW handshake.
- WDATA:
  - wvalid = wr_valid, wdata = wr_data, wr_ready = wready.
  - wlast = 1 when beat count == len.
  - After the last-beat handshake, go to BRESP.
  - len = 0 gives a single beat with wlast = 1.
- BRESP: bready = 1. On bvalid, txn_done pulses next cycle, then IDLE.
- Errors: bresp != 0, rresp != 0, or an rlast count mismatch. Reporting is governed by the optional feature.
- Latency: command accept to arvalid/awvalid = 1 cycle. The last B/R handshake to the next req_ready = 1 cycle (txn_done cycle = IDLE).
- A requester that deasserts req_valid before its grant is simply not served; there is no lockout.
- Simultaneous new request while busy: held off with req_ready = 0 until IDLE.

Optional Feature:
- Macro: AXI_SCHED_ERR_CNT_EN.
- Defined: err_cnt increments by 1 per error event. At most one event per cycle, since only one channel is active at a time. err_cnt saturates at 16'hFFFF and clears on reset.
- Undefined: err_cnt is tied to 0 and no counter logic is built.

Test Plan:
- Req0 read, addr 0x1000, len 7; slave answers 8 beats with rlast on beat 8 -> arvalid 1 cycle after accept, 8 rd_valid beats with data unchanged, rd_last on beat 8, one txn_done pulse, gnt_id = 0.
- Req1 write, addr 0x2000, len 3; wready toggled every other cycle -> 4 W beats, wlast only on the 4th, wvalid never before the AW handshake, bready = 1 until bvalid, txn_done.
- Both requesters valid continuously for 4 transactions -> grants alternate 0, 1, 0, 1.
- Write with bresp = 2'b10 and read with rlast on beat 3 of len 7 (macro defined) -> err_cnt = 2. Same stimulus with the macro undefined -> err_cnt = 0.
- rstn pulsed low during WDATA beat 2 -> wvalid, wr_ready and busy drop asynchronously; after release req_ready returns in IDLE with requester 0 preferred on a tie.
- Len 0 write with arready/awready delayed 5 cycles -> awvalid held 5 cycles, single beat with wlast = 1, correct completion.
